// File: rtl/crc8_frame_pkg.sv
// Shared constants for the CRC-8 frame sequencer: FSM state codes,
// default sizing and the word-counter width helper.
package crc8_frame_pkg;

   localparam int DEF_MAX_WORDS = 64;
   localparam int DEF_TIMEOUT   = 8;

   // FSM state codes
   localparam logic [2:0] ST_CLR       = 3'd0;
   localparam logic [2:0] ST_WAIT_WORD = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_HI   = 3'd3;
   localparam logic [2:0] ST_WAIT_LO   = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   // Counter width able to hold 0..max_words inclusive
   function automatic int wcnt_width(input int max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/crc8_frame_wdog.sv
// Watchdog for the engine busy handshake: counts enabled cycles after a
// clear and flags expiry on the TIMEOUT-th enabled cycle.
module crc8_frame_wdog
   import crc8_frame_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_cnt;

   // Count waiting cycles; saturate once the limit is reached
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_i)
         r_cnt <= '0;
      else if (enable_i && !expired_o)
         r_cnt <= r_cnt + 1'b1;
   end

   assign expired_o = enable_i && (r_cnt == LAST_CNT);

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer for the bit-serial CRC-8 engine: feeds accepted words
// to the engine one at a time, then reports CRC, match, count and errors.
module crc8_frame_ctrl
   import crc8_frame_pkg::*;
#(
   parameter int MAX_WORDS = DEF_MAX_WORDS,
   parameter int WCNT_W    = wcnt_width(MAX_WORDS),
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [15:0]       s_data_i,
   input  logic              s_valid_i,
   input  logic              s_last_i,
   input  logic [7:0]        s_exp_crc_i,
   output logic              s_ready_o,
   output logic              crc_rst_o,
   output logic              crc_start_o,
   output logic [15:0]       crc_val_o,
   input  logic              crc_busy_i,
   input  logic [7:0]        crc_result_i,
   output logic [7:0]        m_crc_o,
   output logic              m_match_o,
   output logic [WCNT_W-1:0] m_words_o,
   output logic              m_trunc_o,
   output logic              m_timeout_o,
   output logic              m_valid_o,
   input  logic              m_ready_i
);

   localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WORDS);

   logic [2:0]        r_state;
   logic [15:0]       r_val;
   logic              r_last;
   logic [7:0]        r_exp;
   logic [WCNT_W-1:0] r_wcnt;
   logic [7:0]        r_crc;
   logic              r_match;
   logic              r_trunc;
   logic              r_tmo;
   logic              w_expired;

   crc8_frame_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clear_i   ((r_state == ST_ISSUE) || (r_state == ST_CLR)),
      .enable_i  (r_state == ST_WAIT_HI),
      .expired_o (w_expired)
   );

   // Frame FSM plus word/result registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state <= ST_CLR;
         r_val   <= '0;
         r_last  <= 1'b0;
         r_exp   <= '0;
         r_wcnt  <= '0;
         r_crc   <= '0;
         r_match <= 1'b0;
         r_trunc <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLR: begin
               r_last  <= 1'b0;
               r_exp   <= '0;
               r_wcnt  <= '0;
               r_crc   <= '0;
               r_match <= 1'b0;
               r_trunc <= 1'b0;
               r_tmo   <= 1'b0;
               r_state <= ST_WAIT_WORD;
            end
            ST_WAIT_WORD: begin
               if (s_valid_i) begin
                  r_val  <= s_data_i;
                  r_last <= s_last_i;
                  if (s_last_i)
                     r_exp <= s_exp_crc_i;
                  if (r_wcnt != MAX_CNT)
                     r_wcnt <= r_wcnt + 1'b1;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT_HI;
            ST_WAIT_HI: begin
               if (crc_busy_i) begin
                  r_state <= ST_WAIT_LO;
               end else if (w_expired) begin
                  // engine never answered: report whatever it holds
                  r_tmo   <= 1'b1;
                  r_crc   <= crc_result_i;
                  r_state <= ST_DONE;
               end
            end
            ST_WAIT_LO: begin
               if (!crc_busy_i) begin
                  r_crc <= crc_result_i;
                  if (r_last) begin
                     r_match <= (crc_result_i == r_exp);
                     r_state <= ST_DONE;
                  end else if (r_wcnt == MAX_CNT) begin
                     r_trunc <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_WAIT_WORD;
                  end
               end
            end
            ST_DONE: begin
               if (m_ready_i)
                  r_state <= ST_CLR;
            end
            default: r_state <= ST_CLR;
         endcase
      end
   end

   // engine clear also covers the cycles the sequencer itself is held in reset
   assign crc_rst_o   = !rst_n_i || (r_state == ST_CLR);
   assign s_ready_o   = rst_n_i && (r_state == ST_WAIT_WORD);
   assign crc_start_o = rst_n_i && (r_state == ST_ISSUE);
   assign crc_val_o   = r_val;
   assign m_valid_o   = (r_state == ST_DONE);
   assign m_crc_o     = r_crc;
   assign m_match_o   = r_match;
   assign m_words_o   = r_wcnt;
   assign m_trunc_o   = r_trunc;
   assign m_timeout_o = r_tmo;

endmodule
